carry_look_ahead_adder: RTL and testbench
=========================================

Name: carry_look_ahead_adder

Overview:
- WIDTH-bit carry-look-ahead adder with a single registered output stage, for datapaths that need a fast add with one cycle of latency.
- Carries are computed from generate/propagate terms in 4-bit lookahead groups, with a second lookahead level across groups. There is no ripple chain.
- Registered block propagate/generate outputs allow cascading into wider adders.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be a multiple of 4, minimum 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- InputA  input  WIDTH  addend A, unsigned.
- InputB  input  WIDTH  addend B, unsigned.
- InputCarry  input  1  carry into bit 0.
- SumOut  output  WIDTH  registered (A + B + Cin) mod 2^WIDTH.
- CarryOut  output  1  registered carry out of bit WIDTH-1.
- BlockP  output  1  registered block propagate: AND of all bit propagates.
- BlockG  output  1  registered block generate: carry out of the MSB assuming Cin=0.

Behaviour:
- Bit terms:
  - g[i] = A[i] & B[i]
  - p[i] = A[i] ^ B[i]
  - p uses XOR so it can be reused for the sum.
- Group level (4-bit groups), carries expanded in two-level sum-of-products form, not chained:
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 and c4 follow the same expansion.
  - Each group also produces group P (AND of its four p) and group G (lookahead G without c0).
- Second level: group carry-ins are derived from group P/G and InputCarry using the same lookahead equations.
  - For WIDTH=4 this reduces to the single group.
- Sum bit: s[i] = p[i] ^ c[i].
- Carry out: CarryOut = c[WIDTH].
- Register stage:
  - All four outputs are captured on the rising clk edge.
  - Latency is exactly 1 cycle: inputs present before edge N appear on outputs after edge N.
  - Throughput is one add per cycle; no handshake.
  - Inputs are sampled every edge; outputs update every edge.
- Reset:
  - rst=1 asynchronously forces SumOut=0, CarryOut=0, BlockP=0, BlockG=0, independent of clk.
  - Outputs stay 0 while rst is high.
  - The first capture happens on the first rising edge after rst deasserts.
  - Reset asserted mid-stream discards the in-flight result.
- Arithmetic rules:
  - Unsigned arithmetic; no overflow flag.
  - Wrap-around is modulo 2^WIDTH, with the dropped bit on CarryOut.
  - {CarryOut, SumOut} must always equal A + B + Cin, including the maximum case all-ones + all-ones + 1.
- Block terms:
  - BlockP and BlockG do not depend on InputCarry.
  - Identity: CarryOut == BlockG | (BlockP & InputCarry) for the registered operand set.
- Purely synchronous datapath apart from reset: no latches, no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst with A=1111, B=1111, Cin=1 while clocking -> all outputs 0. Deassert rst -> after the next edge, SumOut=1111, CarryOut=1.
- Basic adds (WIDTH=4), each checked one cycle after apply:
  - 0000+0000+0 -> Sum 0000, Cout 0.
  - 0101+0011+0 -> Sum 1000, Cout 0.
- Full carry propagation:
  - 1111+0001+0 -> Sum 0000, Cout 1, BlockP 0, BlockG 1.
  - 1010+0101+1 -> Sum 0000, Cout 1, BlockP 1, BlockG 0.
- Maximum operands: 1111+1111+1 -> Sum 1111, Cout 1, BlockP 0, BlockG 1.
- Pipelining: apply a new operand set every cycle for 16 back-to-back vectors. Each output must match the vector from the previous edge, with no bubbles.
- Exhaustive and wide:
  - WIDTH=4: all 512 combinations of A, B, Cin checked against A+B+Cin after 1 cycle.
  - WIDTH=16: random vectors plus FFFF+0000+1 -> Sum 0000, Cout 1.

Source files
------------

// File: rtl/carry_look_ahead_adder_if.sv
// carry_look_ahead_adder_if: operand inputs (InputA/InputB/InputCarry) and registered results (SumOut/CarryOut/BlockP/BlockG)
interface carry_look_ahead_adder_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic InputCarry;
  logic [WIDTH-1:0] SumOut;
  logic CarryOut;
  logic BlockP;
  logic BlockG;
  modport master (output InputA, InputB, InputCarry, input SumOut, CarryOut, BlockP, BlockG);
  modport slave (input InputA, InputB, InputCarry, output SumOut, CarryOut, BlockP, BlockG);
endinterface

// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: two-level 4-bit-group CLA, one register stage; ports clk, rst (async high), bus (slave: A/B/Cin in, Sum/Cout/BlockP/BlockG out)
module carry_look_ahead_adder #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  carry_look_ahead_adder_if.slave bus
);
  localparam int NG = WIDTH / 4;
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    cla4[0] = c0;
    cla4[1] = g[0] | (p[0] & c0);
    cla4[2] = g[1] | (p[1] & g[0]) | ((&p[1:0]) & c0);
    cla4[3] = g[2] | (p[2] & g[1]) | ((&p[2:1]) & g[0]) | ((&p[2:0]) & c0);
  endfunction
  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    gen4 = g[3] | (p[3] & g[2]) | ((&p[3:2]) & g[1]) | ((&p[3:1]) & g[0]);
  endfunction
  logic [WIDTH-1:0] g, p, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0] cg;
  logic bg, t;
  assign g = bus.InputA & bus.InputB;
  assign p = bus.InputA ^ bus.InputB;
  for (genvar k = 0; k < NG; k++) begin : grp
    assign gp[k] = &p[4*k +: 4];
    assign gg[k] = gen4(g[4*k +: 4], p[4*k +: 4]);
    assign c[4*k +: 4] = cla4(g[4*k +: 4], p[4*k +: 4], cg[k]);
  end
  // second level: each group carry-in is a flat OR of group-generate terms, no chaining
  always_comb begin
    cg = '0;
    bg = 1'b0;
    t = 1'b0;
    cg[0] = bus.InputCarry;
    for (int i = 1; i <= NG; i++) begin
      for (int j = 0; j < i; j++) begin
        t = gg[j];
        for (int m = j + 1; m < i; m++) t = t & gp[m];
        cg[i] = cg[i] | t;
      end
      t = bus.InputCarry;
      for (int m = 0; m < i; m++) t = t & gp[m];
      cg[i] = cg[i] | t;
    end
    for (int j = 0; j < NG; j++) begin
      t = gg[j];
      for (int m = j + 1; m < NG; m++) t = t & gp[m];
      bg = bg | t;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.SumOut <= '0;
      bus.CarryOut <= 1'b0;
      bus.BlockP <= 1'b0;
      bus.BlockG <= 1'b0;
    end else begin
      bus.SumOut <= p ^ c;
      bus.CarryOut <= cg[NG];
      bus.BlockP <= &gp;
      bus.BlockG <= bg;
    end
  end
endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// tb_carry_look_ahead_adder: random and directed checks of 4- and 16-bit adders against arithmetic reference
module tb_carry_look_ahead_adder;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  carry_look_ahead_adder_if #(.WIDTH(4)) i4 ();
  carry_look_ahead_adder_if #(.WIDTH(16)) i16 ();
  carry_look_ahead_adder #(.WIDTH(4)) d4 (.clk(clk), .rst(rst), .bus(i4));
  carry_look_ahead_adder #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .bus(i16));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [15:0] x, input logic [15:0] y, input logic z);
    i4.InputA = a;
    i4.InputB = b;
    i4.InputCarry = ci;
    i16.InputA = x;
    i16.InputB = y;
    i16.InputCarry = z;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_sum4"}, 32'(i4.SumOut), 0);
    check({tag, "_flags4"}, {29'd0, i4.CarryOut, i4.BlockP, i4.BlockG}, 0);
    check({tag, "_sum16"}, 32'(i16.SumOut), 0);
    check({tag, "_flags16"}, {29'd0, i16.CarryOut, i16.BlockP, i16.BlockG}, 0);
  endtask
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [15:0] x, input logic [15:0] y, input logic z);
    int e4, n4, e16, n16;
    drive(a, b, ci, x, y, z);
    @(posedge clk);
    #1;
    e4 = int'(a) + int'(b) + int'(ci);
    n4 = int'(a) + int'(b);
    e16 = int'(x) + int'(y) + int'(z);
    n16 = int'(x) + int'(y);
    check("sum4", 32'(i4.SumOut), 32'(e4 % 16));
    check("cout4", 32'(i4.CarryOut), 32'(e4 / 16));
    check("bp4", 32'(i4.BlockP), 32'((a ^ b) == 4'hf));
    check("bg4", 32'(i4.BlockG), 32'(n4 / 16));
    check("id4", 32'(i4.CarryOut), 32'(i4.BlockG | (i4.BlockP & ci)));
    check("sum16", 32'(i16.SumOut), 32'(e16 % 65536));
    check("cout16", 32'(i16.CarryOut), 32'(e16 / 65536));
    check("bp16", 32'(i16.BlockP), 32'((x ^ y) == 16'hffff));
    check("bg16", 32'(i16.BlockG), 32'(n16 / 65536));
  endtask
  initial begin
    rst = 1'b1;
    drive(4'hf, 4'hf, 1'b1, 16'hffff, 16'hffff, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b0;
    run(4'hf, 4'hf, 1'b1, 16'hffff, 16'hffff, 1'b1);
    check("rst_exit_sum", 32'(i4.SumOut), 32'hf);
    run(4'h0, 4'h0, 1'b0, 16'hffff, 16'h0000, 1'b1);
    check("wide_wrap_sum", 32'(i16.SumOut), 0);
    check("wide_wrap_cout", 32'(i16.CarryOut), 1);
    run(4'h5, 4'h3, 1'b0, 16'h1234, 16'h4321, 1'b0);
    check("basic_sum", 32'(i4.SumOut), 32'h8);
    run(4'hf, 4'h1, 1'b0, 16'h00ff, 16'h0001, 1'b0);
    check("prop_flags", {29'd0, i4.CarryOut, i4.BlockP, i4.BlockG}, 32'b101);
    run(4'ha, 4'h5, 1'b1, 16'haaaa, 16'h5555, 1'b1);
    check("prop2_flags", {29'd0, i4.CarryOut, i4.BlockP, i4.BlockG}, 32'b110);
    run(4'hf, 4'hf, 1'b1, 16'hffff, 16'hffff, 1'b1);
    check("max_flags", {29'd0, i4.CarryOut, i4.BlockP, i4.BlockG}, 32'b101);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 16; i++)
      run(4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 512; i++)
      run(4'(i >> 5), 4'(i >> 1), 1'(i), 16'($urandom), 16'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
